// File: rtl/gyro_pkg.sv
// Shared definitions for the gyro read controller: FSM states and default SPI command words.
package gyro_pkg;

    localparam int unsigned CMD_W = 16;

    typedef enum logic [2:0] {
        RST_WT,
        CFG,
        CFG_WT,
        IDLE,
        RD_L,
        RD_L_WT,
        RD_H,
        RD_H_WT
    } state_t;

    localparam logic [CMD_W-1:0] INIT_CYC_DEF = 16'hFFFF;
    localparam logic [CMD_W-1:0] CFG0_DEF     = 16'h0D02;
    localparam logic [CMD_W-1:0] CFG1_DEF     = 16'h1160;
    localparam logic [CMD_W-1:0] CFG2_DEF     = 16'h1440;
    localparam logic [CMD_W-1:0] RD_L_CMD_DEF = 16'hA600;
    localparam logic [CMD_W-1:0] RD_H_CMD_DEF = 16'hA700;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gyro_rd_ctrl.sv
// Sequences sensor power-up wait, configuration writes and yaw-rate reads over the SPI monarch.
module gyro_rd_ctrl
    import gyro_pkg::*;
#(
    parameter logic [CMD_W-1:0] INIT_CYC = INIT_CYC_DEF,
    parameter logic [CMD_W-1:0] CFG0     = CFG0_DEF,
    parameter logic [CMD_W-1:0] CFG1     = CFG1_DEF,
    parameter logic [CMD_W-1:0] CFG2     = CFG2_DEF,
    parameter logic [CMD_W-1:0] RD_L_CMD = RD_L_CMD_DEF,
    parameter logic [CMD_W-1:0] RD_H_CMD = RD_H_CMD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             INT,
    output logic             snd,
    output logic [CMD_W-1:0] cmd,
    input  logic             done,
    input  logic [CMD_W-1:0] resp,
    output logic [CMD_W-1:0] yaw_rt,
    output logic             vld,
    output logic             cfg_done
);

    state_t           state;
    logic [CMD_W-1:0] wait_cnt;
    logic [1:0]       cfg_idx;
    logic [7:0]       low_byte;
    logic             int_s;
    logic             done_q;
    logic             done_rise;
    logic             unused_resp_hi;

    function automatic logic [CMD_W-1:0] cfg_word(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_word = CFG0;
            2'd1:    cfg_word = CFG1;
            default: cfg_word = CFG2;
        endcase
    endfunction

    sync_2ff u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (INT),
        .q   (int_s)
    );

    // done_q resets high so a done level already present at reset is not an edge
    assign done_rise      = done & ~done_q;
    assign unused_resp_hi = ^resp[15:8];

    // snd and cmd are launched on entry to each command state, so snd lasts exactly that state's cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RST_WT;
            wait_cnt <= '0;
            cfg_idx  <= 2'd0;
            low_byte <= 8'h00;
            done_q   <= 1'b1;
            snd      <= 1'b0;
            cmd      <= '0;
            yaw_rt   <= '0;
            vld      <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            done_q <= done;
            snd    <= 1'b0;
            vld    <= 1'b0;
            case (state)
                RST_WT: begin
                    if (wait_cnt == INIT_CYC) begin
                        state <= CFG;
                        snd   <= 1'b1;
                        cmd   <= cfg_word(cfg_idx);
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                CFG: state <= CFG_WT;
                CFG_WT: begin
                    if (done_rise) begin
                        if (cfg_idx == 2'd2) begin
                            state    <= IDLE;
                            cfg_done <= 1'b1;
                        end else begin
                            cfg_idx <= cfg_idx + 2'd1;
                            state   <= CFG;
                            snd     <= 1'b1;
                            cmd     <= cfg_word(cfg_idx + 2'd1);
                        end
                    end
                end
                IDLE: begin
                    if (int_s) begin
                        state <= RD_L;
                        snd   <= 1'b1;
                        cmd   <= RD_L_CMD;
                    end
                end
                RD_L: state <= RD_L_WT;
                RD_L_WT: begin
                    if (done_rise) begin
                        low_byte <= resp[7:0];
                        state    <= RD_H;
                        snd      <= 1'b1;
                        cmd      <= RD_H_CMD;
                    end
                end
                RD_H: state <= RD_H_WT;
                RD_H_WT: begin
                    if (done_rise) begin
                        yaw_rt <= {resp[7:0], low_byte};
                        vld    <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= RST_WT;
            endcase
        end
    end

endmodule

// File: tb/tb_gyro_rd_ctrl.sv
// Randomized self-checking bench for gyro_rd_ctrl with an inline SPI serf model.
module tb_gyro_rd_ctrl;
    import gyro_pkg::*;

    localparam logic [15:0] INIT_CYC = 16'd100;

    logic        clk = 1'b0;
    logic        rst;
    logic        INT;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;
    logic [15:0] yaw_rt;
    logic        vld;
    logic        cfg_done;

    int n_chk = 0;
    int n_pass = 0;
    int snd_seen = 0;
    int vld_seen = 0;
    int snd_dbl = 0;
    int vld_dbl = 0;
    int wait_snd_err = 0;
    int cmd_hold_err = 0;
    int exp_snd = 0;
    int exp_vld = 0;
    logic snd_prev = 1'b0;
    logic vld_prev = 1'b0;

    always #5 clk = ~clk;

    gyro_rd_ctrl #(.INIT_CYC(INIT_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .INT      (INT),
        .snd      (snd),
        .cmd      (cmd),
        .done     (done),
        .resp     (resp),
        .yaw_rt   (yaw_rt),
        .vld      (vld),
        .cfg_done (cfg_done)
    );

    // Tally strobes for end-of-run totals and back-to-back detection
    always @(negedge clk) begin
        if (snd === 1'b1) snd_seen++;
        if (vld === 1'b1) vld_seen++;
        if (snd === 1'b1 && snd_prev === 1'b1) snd_dbl++;
        if (vld === 1'b1 && vld_prev === 1'b1) vld_dbl++;
        snd_prev = snd;
        vld_prev = vld;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    // Advance negedge by negedge until snd is seen, bounded; n accumulates cycles waited
    task automatic wait_snd(input string tag, inout int n);
        int k = 0;
        while (snd !== 1'b1 && k < 2000) begin
            @(negedge clk);
            n++;
            k++;
        end
        chk({tag, "_snd"}, 32'(snd), 32'd1);
    endtask

    // Serf model: accept one command, hold done low for lat cycles, then return rsp
    task automatic spi_txn(input string tag, input logic [15:0] exp_cmd, input logic [15:0] rsp,
                           input int lat, input bit glitch, inout int n);
        wait_snd(tag, n);
        if (snd !== 1'b1) return;
        chk({tag, "_cmd"}, 32'(cmd), 32'(exp_cmd));
        exp_snd++;
        done = 1'b0;
        if (glitch) INT = 1'b0;
        for (int i = 0; i < lat; i++) begin
            if (glitch) begin
                #1 INT = 1'b1;
                #2 INT = 1'b0;
            end
            @(negedge clk);
            if (snd !== 1'b0) wait_snd_err++;
            if (cmd !== exp_cmd) cmd_hold_err++;
        end
        resp = rsp;
        done = 1'b1;
    endtask

    task automatic run_config(input int n0);
        int n = n0;
        spi_txn("cfg0", CFG0_DEF, 16'($urandom), int'($urandom_range(1, 6)), 1'b0, n);
        chk("first_snd_lat", 32'(n), 32'd101);
        spi_txn("cfg1", CFG1_DEF, 16'($urandom), int'($urandom_range(1, 6)), 1'b0, n);
        chk("cfg_done_early", 32'(cfg_done), 32'd0);
        spi_txn("cfg2", CFG2_DEF, 16'($urandom), int'($urandom_range(1, 6)), 1'b0, n);
        @(negedge clk);
        chk("cfg_done", 32'(cfg_done), 32'd1);
    endtask

    // Reference: yaw is the signed 16-bit value high_byte*256 + low_byte
    task automatic read_pair(input string tag, input logic [15:0] rl, input logic [15:0] rh,
                             input bit keep_int, input bit glitch);
        int n = 0;
        int hi, lo, v;
        logic [15:0] exp_yaw;
        hi = int'($signed(rh[7:0]));
        lo = int'(rl[7:0]);
        v  = hi * 256 + lo;
        exp_yaw = 16'(v);
        spi_txn({tag, "_l"}, RD_L_CMD_DEF, rl, int'($urandom_range(1, 6)), glitch, n);
        if (!keep_int) INT = 1'b0;
        spi_txn({tag, "_h"}, RD_H_CMD_DEF, rh, int'($urandom_range(1, 6)), 1'b0, n);
        exp_vld++;
        @(negedge clk);
        chk({tag, "_vld"}, 32'(vld), 32'd1);
        chk({tag, "_yaw"}, 32'(yaw_rt), 32'(exp_yaw));
        @(negedge clk);
        chk({tag, "_vld_off"}, 32'(vld), 32'd0);
        chk({tag, "_yaw_hold"}, 32'(yaw_rt), 32'(exp_yaw));
    endtask

    initial begin
        int n;
        rst  = 1'b1;
        INT  = 1'b0;
        done = 1'b1;
        resp = 16'h0000;
        repeat (4) @(negedge clk);
        chk("rst_snd", 32'(snd), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_yaw", 32'(yaw_rt), 32'd0);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        rst = 1'b0;
        run_config(0);

        INT = 1'b1;
        read_pair("basic", 16'h0034, 16'h0012, 1'b0, 1'b0);
        INT = 1'b1;
        read_pair("neg", 16'hABF0, 16'hABFF, 1'b0, 1'b0);

        INT = 1'b1;
        read_pair("held_a", 16'($urandom), 16'($urandom), 1'b1, 1'b0);
        read_pair("held_b", 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        repeat (20) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            repeat (int'($urandom_range(0, 5))) @(negedge clk);
            INT = 1'b1;
            read_pair("rnd", 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        end

        INT = 1'b1;
        read_pair("glitch", 16'($urandom), 16'($urandom), 1'b0, 1'b1);
        repeat (20) @(negedge clk);

        // Reset while the high-byte read is in flight; its done arrives during the power-up wait
        INT = 1'b1;
        n = 0;
        spi_txn("rs_l", RD_L_CMD_DEF, 16'($urandom), 2, 1'b0, n);
        INT = 1'b0;
        wait_snd("rs_h", n);
        chk("rs_h_cmd", 32'(cmd), 32'(RD_H_CMD_DEF));
        exp_snd++;
        done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_vld", 32'(vld), 32'd0);
        chk("rs_yaw", 32'(yaw_rt), 32'd0);
        chk("rs_cfg_done", 32'(cfg_done), 32'd0);
        chk("rs_snd", 32'(snd), 32'd0);
        rst = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            n++;
        end
        resp = 16'hBEEF;
        done = 1'b1;
        run_config(n);
        INT = 1'b1;
        read_pair("post_rst", 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        repeat (10) @(negedge clk);

        chk("snd_total", 32'(snd_seen), 32'(exp_snd));
        chk("vld_total", 32'(vld_seen), 32'(exp_vld));
        chk("snd_back_to_back", 32'(snd_dbl), 32'd0);
        chk("vld_back_to_back", 32'(vld_dbl), 32'd0);
        chk("snd_in_wait", 32'(wait_snd_err), 32'd0);
        chk("cmd_hold", 32'(cmd_hold_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
